// File: rtl/xgmii_start_align.sv
// -----------------------------------------------------------------------------
// xgmii_start_align
//
// XGMII receive-side lane aligner. Each frame is re-aligned so that its Start
// character lands in lane 0 of the output word. Start may arrive on any 4-lane
// boundary. The data is realigned by a funnel shifter over {hold, incoming}
// words. Frame tracking and protocol-error detection run alongside it.
//
// Word packing (in and out): {ctrl[LANES-1:0], data[LANES*8-1:0]}.
// Lane i is data[8i+7:8i] together with ctrl[i].
//
// Optional build macro:
//   XGMII_ALIGN_STATS_EN - builds the saturating err_cnt/frm_cnt counters.
//                          When it is undefined, both counters read 0 and
//                          clr_stats is ignored.
// -----------------------------------------------------------------------------
module xgmii_start_align #(
  parameter int LANES  = 8,   // 8 or 16
  parameter int STAT_W = 16,
  localparam int SH_W  = ($clog2(LANES / 4) > 1) ? $clog2(LANES / 4) : 1,
  localparam int W     = LANES * 9
) (
  input  logic              xgmii_clk,
  input  logic              sys_rst_n,
  input  logic              in_vld,
  input  logic [W-1:0]      in_d,
  input  logic              clr_stats,
  output logic              out_vld,
  output logic [W-1:0]      out_d,
  output logic              out_sof,
  output logic              out_eof,
  output logic [SH_W-1:0]   shift,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] frm_cnt
);

  localparam int NGRP = LANES / 4;

  // One lane as {ctrl, data}
  typedef logic [8:0] lane_t;

  localparam lane_t START_CH = 9'h1FB;
  localparam lane_t TERM_CH  = 9'h1FD;
  localparam lane_t IDLE_CH  = 9'h107;

  localparam logic [W-1:0] IDLE_WORD = {{LANES{1'b1}}, {LANES{8'h07}}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]    h_q;      // previous valid input word
  logic [SH_W-1:0] off_q;    // alignment offset in 4-lane groups
  logic [0:0]      state_q;

  // ---------------------------------------------------------------------------
  // Lane views
  // ---------------------------------------------------------------------------
  lane_t in_lane  [LANES];
  lane_t cat_lane [2*LANES];  // hold lanes first, then incoming lanes

  // Split the packed words into lanes and build the funnel source window.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_lane[i]          = {in_d[LANES*8+i], in_d[8*i +: 8]};
      cat_lane[i]         = {h_q[LANES*8+i],  h_q[8*i +: 8]};
      cat_lane[LANES + i] = in_lane[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Start / Terminate detection on the incoming word
  // ---------------------------------------------------------------------------
  logic            start_found;  // aligned Start present
  logic [SH_W-1:0] start_grp;    // group of the lowest aligned Start
  logic            start_seen;
  logic            multi_start;
  logic            misaligned;
  logic            term_before;  // Terminate below the Start lane (or no Start)
  logic            term_after;   // Terminate above the Start lane

  // Scan the lanes upwards. Terminates are classified relative to the first
  // aligned Start. Misaligned and repeated Starts are flagged.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    start_found = 1'b0;
    start_grp   = '0;
    start_seen  = 1'b0;
    multi_start = 1'b0;
    misaligned  = 1'b0;
    term_before = 1'b0;
    term_after  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane[i] == TERM_CH) begin
        if (start_found) term_after  = 1'b1;
        else             term_before = 1'b1;
      end
      if (in_lane[i] == START_CH) begin
        if (start_seen) multi_start = 1'b1;
        start_seen = 1'b1;
        if ((i % 4) != 0) begin
          misaligned = 1'b1;
        end else if (!start_found) begin
          start_found = 1'b1;
          start_grp   = SH_W'(i / 4);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine and error event
  // ---------------------------------------------------------------------------
  logic [0:0] state_d;
  logic       err_ev;

  // A Terminate ahead of the Start lane ends the running frame. A Start inside
  // a frame that was not closed first is an error but still realigns.
  always_comb begin
    state_d = state_q;
    err_ev  = misaligned | multi_start;
    if (start_found) begin
      if (state_q == ST_FRAME && !term_before) err_ev = 1'b1;
      if (state_q == ST_IDLE  &&  term_before) err_ev = 1'b1;
      state_d = term_after ? ST_IDLE : ST_FRAME;
    end else if (term_before) begin
      if (state_q == ST_IDLE) err_ev  = 1'b1;
      else                    state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Funnel shifter
  // ---------------------------------------------------------------------------
  lane_t        out_lane [LANES];
  logic [W-1:0] out_word;
  logic         sof_d;
  logic         eof_d;

  // Output lane j takes window lane 4*off + j. When a new Start is accepted,
  // incoming lanes are replaced with Idle. This matters because those lanes
  // reappear from the hold register under the new offset and would otherwise
  // be duplicated.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      out_lane[j] = IDLE_CH;
      for (int o = 0; o < NGRP; o++) begin
        if (off_q == SH_W'(o)) begin
          if (start_found && (4*o + j >= LANES)) out_lane[j] = IDLE_CH;
          else                                   out_lane[j] = cat_lane[4*o + j];
        end
      end
    end
  end

  // Repack the output lanes and decode the Start/Terminate flags.
  always_comb begin
    out_word = '0;
    eof_d    = 1'b0;
    sof_d    = (out_lane[0] == START_CH);
    for (int j = 0; j < LANES; j++) begin
      out_word[8*j +: 8]     = out_lane[j][7:0];
      out_word[LANES*8 + j]  = out_lane[j][8];
      if (out_lane[j] == TERM_CH) eof_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // The datapath and alignment state advance only on valid input words.
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    // NOTE: state registers use non-blocking assignments. All of them then
    // sample pre-edge values, whatever order the statements are written in.
    if (!sys_rst_n) begin
      out_vld <= 1'b0;
      out_d   <= IDLE_WORD;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      h_q     <= IDLE_WORD;
      off_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_d   <= out_word;
        out_sof <= sof_d;
        out_eof <= eof_d;
        h_q     <= in_d;
        state_q <= state_d;
        if (start_found) off_q <= start_grp;
      end
    end
  end

  assign shift = off_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef XGMII_ALIGN_STATS_EN
  logic [STAT_W-1:0] err_q;
  logic [STAT_W-1:0] frm_q;

  // Saturating counters. A clear takes precedence over a same-cycle increment.
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_q <= '0;
      frm_q <= '0;
    end else if (clr_stats) begin
      err_q <= '0;
      frm_q <= '0;
    end else if (in_vld) begin
      if (err_ev && err_q != '1)      err_q <= err_q + 1'b1;
      if (start_found && frm_q != '1) frm_q <= frm_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
  assign frm_cnt = frm_q;
`else
  // The counters are not built in this configuration.
  logic unused_stats;
  assign unused_stats = clr_stats | err_ev;
  assign err_cnt      = '0;
  assign frm_cnt      = '0;
`endif

endmodule
